// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_ctrl
//  Purpose  : Run-time programmable clock divider. Produces a registered
//             divided clock (div_out) and a period-start strobe (tick) from
//             clk. New divide ratios arrive over a valid/ready handshake and
//             only take effect on a period boundary, so no output period is
//             ever cut short or stretched.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, rising edge
//    rst        in   synchronous active-high reset
//    en         in   run request (high = run, low = finish period and stop)
//    cfg_valid  in   new ratio offered
//    cfg_div    in   offered ratio N (CNT_W bits)
//    cfg_ready  out  controller can accept a ratio
//    cfg_err    out  one-cycle pulse after an illegal offer (N < 2)
//    div_out    out  divided clock, high for floor(N/2) of every N cycles
//    tick       out  one-cycle pulse on the first cycle of each period
//    busy       out  divider is running or finishing a period
//    cur_div    out  ratio currently in effect
// ============================================================================
module clk_div_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pend  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    localparam logic [CNT_W-1:0] c_def_div = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] c_min_div = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    // Needed only for a ratio accepted while draining; in PEND the pending
    // register is valid by construction.
    logic             r_pend_vld;
    logic             r_div_out;
    logic             r_tick;
    logic             r_cfg_err;
    logic             r_cfg_ready;
    logic             r_busy;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cur_div_nxt;
    logic [CNT_W-1:0] w_pend_div_nxt;
    logic             w_pend_vld_nxt;
    logic             w_div_nxt;
    logic             w_tick_nxt;
    logic             w_err_nxt;

    // ------------------------------------------------------------------------
    // Handshake decode and one counting step with the current ratio
    // ------------------------------------------------------------------------
    logic             w_xfer;
    logic             w_legal;
    logic             w_accept;
    logic             w_reject;
    logic [CNT_W-1:0] w_half;
    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_step_cnt;
    logic             w_step_div;

    assign w_xfer    = cfg_valid && r_cfg_ready;
    assign w_legal   = (cfg_div >= c_min_div);
    assign w_accept  = w_xfer && w_legal;
    assign w_reject  = w_xfer && !w_legal;

    assign w_half    = r_cur_div >> 1;
    assign w_wrap    = (r_cnt == (r_cur_div - c_one));
    // Cannot overflow: the increment is only used when cnt < cur_div - 1.
    assign w_cnt_inc = r_cnt + c_one;

    // On a wrap the new period starts at count 0, which is always in the high
    // half because every legal ratio has floor(N/2) >= 1.
    assign w_step_cnt = w_wrap ? '0 : w_cnt_inc;
    assign w_step_div = w_wrap ? 1'b1 : (w_cnt_inc < w_half);

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_div_nxt  = r_cur_div;
        w_pend_div_nxt = r_pend_div;
        w_pend_vld_nxt = r_pend_vld;
        w_div_nxt      = r_div_out;
        w_tick_nxt     = 1'b0;
        w_err_nxt      = w_reject;

        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                w_div_nxt = 1'b0;
                // Loaded before the start check so a ratio offered together
                // with en governs the very first period.
                if (w_accept) begin
                    w_cur_div_nxt = cfg_div;
                end
                if (en) begin
                    w_state_nxt = c_st_run;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end

            c_st_run: begin
                w_cnt_nxt  = w_step_cnt;
                w_div_nxt  = w_step_div;
                w_tick_nxt = w_wrap;
                // A ratio accepted on a boundary edge still waits for the
                // following boundary; the wrap above uses the old ratio.
                if (w_accept) begin
                    w_pend_div_nxt = cfg_div;
                    w_pend_vld_nxt = 1'b1;
                    w_state_nxt    = c_st_pend;
                end else if (!en) begin
                    w_state_nxt = c_st_drain;
                end
            end

            c_st_pend: begin
                w_cnt_nxt  = w_step_cnt;
                w_div_nxt  = w_step_div;
                w_tick_nxt = w_wrap;
                if (w_wrap) begin
                    w_cur_div_nxt  = r_pend_div;
                    w_pend_vld_nxt = 1'b0;
                    w_state_nxt    = en ? c_st_run : c_st_drain;
                end
            end

            c_st_drain: begin
                if (en) begin
                    // Run request came back: keep counting seamlessly.
                    w_cnt_nxt  = w_step_cnt;
                    w_div_nxt  = w_step_div;
                    w_tick_nxt = w_wrap;
                    if (w_accept) begin
                        w_pend_div_nxt = cfg_div;
                        w_pend_vld_nxt = 1'b1;
                        w_state_nxt    = c_st_pend;
                    end else if (r_pend_vld) begin
                        w_state_nxt = c_st_pend;
                    end else begin
                        w_state_nxt = c_st_run;
                    end
                end else begin
                    if (w_accept) begin
                        w_pend_div_nxt = cfg_div;
                        w_pend_vld_nxt = 1'b1;
                    end
                    if (w_wrap) begin
                        // Period complete: park low without a tick. Any ratio
                        // accepted while draining (including on this edge)
                        // becomes current here.
                        w_state_nxt    = c_st_idle;
                        w_cnt_nxt      = '0;
                        w_div_nxt      = 1'b0;
                        w_tick_nxt     = 1'b0;
                        w_pend_vld_nxt = 1'b0;
                        if (w_accept) begin
                            w_cur_div_nxt = cfg_div;
                        end else if (r_pend_vld) begin
                            w_cur_div_nxt = r_pend_div;
                        end
                    end else begin
                        w_cnt_nxt = w_step_cnt;
                        w_div_nxt = w_step_div;
                    end
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
                w_div_nxt   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers. cfg_ready and busy are registered from the next state so they
    // always agree with the state actually entered on this edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_cur_div   <= c_def_div;
            r_pend_div  <= '0;
            r_pend_vld  <= 1'b0;
            r_div_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cur_div   <= w_cur_div_nxt;
            r_pend_div  <= w_pend_div_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_div_out   <= w_div_nxt;
            r_tick      <= w_tick_nxt;
            r_cfg_err   <= w_err_nxt;
            r_cfg_ready <= (w_state_nxt != c_st_pend);
            r_busy      <= (w_state_nxt != c_st_idle);
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign div_out   = r_div_out;
    assign tick      = r_tick;
    assign busy      = r_busy;
    assign cur_div   = r_cur_div;

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time programmable clock-divider controller. Generates a registered divided clock `div_out` and a period-start strobe `tick` from `clk`. The divide ratio is reloaded through a valid/ready configuration handshake; new ratios take effect only at a period boundary, so there are no runt or stretched pulses. It sits between the register/config logic and the clock-divider consumers, replacing fixed divide-by-2 instances wherever the ratio must change at run time.

## Interface
- `CNT_W`, 8: width of the divide ratio and the period counter.
- `DEF_DIV`, 2: ratio loaded at reset. Must satisfy 2 ≤ DEF_DIV ≤ 2^CNT_W−1.

- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run request. High starts the divider; low stops it gracefully.
- `cfg_valid` in 1: a new ratio is offered.
- `cfg_div` in CNT_W: the offered ratio N.
- `cfg_ready` out 1: the controller can accept a ratio.
- `cfg_err` out 1: one-cycle pulse when an offered ratio is illegal (N < 2).
- `div_out` out 1: registered divided clock.
- `tick` out 1: one-cycle pulse on the first `clk` cycle of each output period.
- `busy` out 1: high while in RUN, PEND or DRAIN.
- `cur_div` out CNT_W: the ratio currently in effect.

## Operation
- Handshake: a transfer occurs on an edge where `cfg_valid && cfg_ready`.
  - If N ≥ 2, the ratio is accepted.
  - If N < 2, nothing is stored and `cfg_err` pulses on the next cycle.
- `cfg_ready` = 1 in IDLE, RUN and DRAIN, and 0 in PEND.
- Period counter `cnt` runs 0..N−1 and wraps to 0. H = floor(N/2).
  - `div_out` = 1 for counts 0..H−1 and 0 for counts H..N−1.
  - Duty cycle: 50% for even N; high one cycle shorter than low for odd N.
- A boundary is the edge where `cnt` wraps from N−1 to 0.
- States:
  - IDLE: `div_out` = 0 and `cnt` = 0. An accepted ratio loads `cur_div` on the next edge. `en` = 1 → RUN; the next edge sets `cnt` = 0, `div_out` = 1 and `tick` = 1.
  - RUN: counting. An accepted ratio is stored in a pending register → PEND. `en` = 0 → DRAIN.
  - PEND: counting with the old ratio. At the boundary, `cur_div` ← pending and the new period starts with the new ratio → RUN, or → DRAIN if `en` = 0.
  - DRAIN: the current period completes. At the boundary → IDLE with `div_out` = 0 and no `tick`. If `en` returns to 1 before the boundary → RUN, with no gap in output.
- Simultaneous events:
  - A ratio accepted on the same edge as a boundary is pending, and applies at the following boundary.
  - In DRAIN, an accepted ratio loads `cur_div` at the DRAIN→IDLE boundary.
  - `en` falling in PEND: the pending ratio is still loaded at the boundary, then DRAIN.
- Reset mid-operation: all state is abandoned immediately and the pending ratio is discarded.

## Timing
- Reset values:
  - `div_out` 0, `tick` 0, `cfg_err` 0, `busy` 0.
  - `cfg_ready` 1, `cur_div` DEF_DIV, state IDLE.
- All outputs are registered; none has a combinational path from inputs.
- Start latency: `div_out` rises on the 1st edge after `en` is sampled high in IDLE.
- Output period = exactly `cur_div` `clk` cycles. `tick` coincides with the rising edge of `div_out`.
- Reconfiguration latency: from acceptance to the next boundary, up to N_old cycles, or N_old + (remaining cycles) when acceptance coincides with a boundary.
- `cur_div` updates on the same edge as the first `tick` of the new ratio.

## Test plan
- Reset with `en` = 1 and DEF_DIV = 2 → `div_out` toggles every cycle, `tick` every 2 cycles, `cur_div` = 2.
- Configure N = 5 while IDLE, then `en` = 1 → `div_out` high 2 and low 3 cycles; `tick` period 5.
- Configure N = 4 during RUN at N = 6, mid-period (`cnt` = 2) → `cfg_ready` is 0 for 4 cycles. The current period finishes at 6 cycles, then periods are 4 cycles (2 high, 2 low).
- Offer N = 1, then N = 0 → `cfg_err` pulses once per offer; `cur_div` unchanged; output period unchanged.
- Drop `en` at `cnt` = 1 with N = 8 → 7 more cycles of the period, then `div_out` = 0 and `busy` = 0. Re-raise `en` at `cnt` = 4 instead → continuous output.
- Assert `rst` for one cycle in PEND → all outputs at reset values, pending ratio lost, `cur_div` = DEF_DIV.
